// File: rtl/tmr_resp_distributor_if.sv
// tmr_resp_distributor_if: OBI types plus the request/response bundle between voter, bus and harts.
package tmr_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

interface tmr_resp_distributor_if #(parameter int NHARTS = 3);
  import tmr_obi_pkg::*;
  obi_req_t                voted_req_i;
  obi_req_t                bus_req_o;
  obi_resp_t               bus_resp_i;
  obi_resp_t [NHARTS-1:0]  core_resp_o;
  modport master (output voted_req_i, bus_resp_i, input bus_req_o, core_resp_o);
  modport slave  (input voted_req_i, bus_resp_i, output bus_req_o, core_resp_o);
endinterface

// File: rtl/tmr_resp_distributor.sv
// tmr_resp_distributor: gates voted OBI requests onto the bus, fans responses out to all harts, drains and resyncs on voter errors.
// Optional TMR_RESP_ERR_CNT_EN adds a saturating error-pulse counter on err_cnt_o.
module tmr_resp_distributor #(
  parameter int NHARTS    = 3,
  parameter int MAX_OUTST = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  tmr_resp_distributor_if.slave            bus_if,
  input  logic                             error_i,
  input  logic [NHARTS-1:0]                error_id_i,
  output logic [NHARTS-1:0]                fault_mask_o,
  output logic                             resync_req_o,
  input  logic                             resync_ack_i,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outstanding_o,
  output logic                             protocol_err_o
`ifdef TMR_RESP_ERR_CNT_EN
  ,
  output logic [7:0]                       err_cnt_o
`endif
);
  localparam int CW = $clog2(MAX_OUTST+1);
  typedef enum logic [1:0] {RUN, DRAIN, RESYNC} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NHARTS-1:0] mask_q, mask_d;
  logic rq_q, rq_d, perr_q, perr_d, req_ok, accept, rvalid;
  assign rvalid = bus_if.bus_resp_i.rvalid;
  assign req_ok = bus_if.voted_req_i.req & ~rst_i & (state_q == RUN) & (cnt_q < CW'(MAX_OUTST));
  assign accept = req_ok & bus_if.bus_resp_i.gnt;
  assign cnt_d  = cnt_q + CW'(accept) - CW'(rvalid && cnt_q != '0);
  assign perr_d = perr_q | (rvalid & (cnt_q == '0));
  always_comb begin
    bus_if.bus_req_o = bus_if.voted_req_i;
    bus_if.bus_req_o.req = req_ok;
    for (int h = 0; h < NHARTS; h++) begin
      bus_if.core_resp_o[h].gnt    = accept & ~mask_q[h];
      bus_if.core_resp_o[h].rvalid = rvalid & ~rst_i & ~mask_q[h];
      bus_if.core_resp_o[h].rdata  = bus_if.bus_resp_i.rdata;
    end
  end
  // DRAIN leaves as soon as the last in-flight response is returning, so RESYNC starts with count 0.
  always_comb begin
    state_d = state_q;
    mask_d  = error_i ? mask_q | error_id_i : mask_q;
    rq_d    = rq_q;
    case (state_q)
      RUN:     state_d = error_i ? DRAIN : RUN;
      DRAIN: begin
        if (cnt_q == '0 || (cnt_q == CW'(1) && rvalid)) begin
          state_d = RESYNC;
          rq_d    = 1'b1;
        end
      end
      RESYNC: begin
        if (resync_ack_i) begin
          state_d = RUN;
          mask_d  = '0;
          rq_d    = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      mask_q  <= '0;
      rq_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rq_q    <= rq_d;
      perr_q  <= perr_d;
    end
  end
  assign fault_mask_o   = mask_q;
  assign resync_req_o   = rq_q;
  assign outstanding_o  = cnt_q;
  assign protocol_err_o = perr_q;
`ifdef TMR_RESP_ERR_CNT_EN
  logic [7:0] ecnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) ecnt_q <= '0;
    else if (error_i && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
  end
  assign err_cnt_o = ecnt_q;
`endif
endmodule
